// File: rtl/lsu_data_mem.sv
// lsu_data_mem: byte-addressable RV32 data memory; req (valid/ready/addr/wren/funct3/wdata) in, rsp (valid/ready/rdata/err) out
module lsu_data_mem #(
  parameter int DEPTH = 4096,
  parameter int LATENCY = 1,
  parameter bit INIT_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wren,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [3:0][7:0] mem [DEPTH];
  logic [3:0][7:0] wlanes;
  logic [AW-1:0] idx;
  logic [31:0] word, ldata, rdata_q;
  logic [15:0] h;
  logic [7:0] b;
  logic [3:0] be;
  logic [1:0] sz;
  logic acc, we, err, err_q;
  assign idx = req_addr[AW+1:2];
  assign sz = req_funct3[1:0];
  assign acc = req_ready & req_valid;
  // upper address bits only matter to the range check
  assign err = (req_addr[31:2] >= 30'(DEPTH))
             | (sz == 2'b01 & req_addr[0])
             | (sz == 2'b10 & |req_addr[1:0])
             | (req_wren ? (req_funct3[2] | &sz) : (&sz | &req_funct3[2:1]));
  assign word = mem[idx];
  assign b = word[{req_addr[1:0], 3'b000} +: 8];
  assign h = req_addr[1] ? word[31:16] : word[15:0];
  // funct3[2] selects zero-extension for LBU/LHU
  assign ldata = sz == 2'b10 ? word
               : sz[0] ? {{16{~req_funct3[2] & h[15]}}, h}
               : {{24{~req_funct3[2] & b[7]}}, b};
  assign be = sz == 2'b00 ? 4'b0001 << req_addr[1:0]
            : sz == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wlanes = sz == 2'b00 ? {4{req_wdata[7:0]}} : sz == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign we = acc & req_wren & ~err;
  if (INIT_ZERO) begin : g_clr
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
        for (int l = 0; l < 4; l++) if (be[l]) mem[idx][l] <= wlanes[l];
      end
  end else begin : g_keep
    always_ff @(posedge clk)
      if (we) for (int l = 0; l < 4; l++) if (be[l]) mem[idx][l] <= wlanes[l];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        cnt <= CW'(LATENCY - 1);
        rdata_q <= (err | req_wren) ? '0 : ldata;
        err_q <= err;
      end else if (state == WAIT) cnt <= cnt - 1'b1;
    end
  always_comb begin
    state_n = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = WAIT;
      end
      WAIT: if (cnt == '0) state_n = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err = rsp_valid & err_q;
endmodule

// File: tb/tb_lsu_data_mem.sv
// tb_lsu_data_mem: directed vectors run on LATENCY=1 and LATENCY=3 instances side by side
module tb_lsu_data_mem;
  localparam int DEPTH = 64;
  typedef struct {
    logic [31:0] addr;
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] edata;
    logic        eerr;
    string       name;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_wren = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0] req_funct3 = '0;
  logic rr1, rv1, re1, rr3, rv3, re3;
  logic [31:0] rd1, rd3;
  int total = 0, passed = 0;
  vec_t vecs[$];
  always #5 clk = ~clk;
  lsu_data_mem #(.DEPTH(DEPTH), .LATENCY(1), .INIT_ZERO(1'b0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr1), .req_addr(req_addr),
    .req_wren(req_wren), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_ready(rsp_ready), .rsp_rdata(rd1), .rsp_err(re1));
  lsu_data_mem #(.DEPTH(DEPTH), .LATENCY(3), .INIT_ZERO(1'b0)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr3), .req_addr(req_addr),
    .req_wren(req_wren), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_err(re3));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [2:0] f,
                              input logic [31:0] d, input logic [31:0] ed, input logic ee, input string nm);
    vec_t v;
    v.addr = a; v.wren = w; v.f3 = f; v.wdata = d; v.edata = ed; v.eerr = ee; v.name = nm;
    return v;
  endfunction
  task automatic xact(input vec_t v);
    int c1 = -1, c3 = -1;
    logic [31:0] d1 = 'x, d3 = 'x;
    logic e1 = 1'bx, e3 = 1'bx;
    @(negedge clk);
    req_addr = v.addr; req_wren = v.wren; req_funct3 = v.f3; req_wdata = v.wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({v.name, " accept"}, {30'b0, rr1, rr3}, 32'h0);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (c1 < 0 && rv1) begin c1 = i; d1 = rd1; e1 = re1; end
      if (c3 < 0 && rv3) begin c3 = i; d3 = rd3; e3 = re3; end
    end
    chk({v.name, " lat1"}, c1, 32'd1);
    chk({v.name, " lat3"}, c3, 32'd3);
    chk({v.name, " data1"}, d1, v.edata);
    chk({v.name, " data3"}, d3, v.edata);
    chk({v.name, " err1/err3"}, {30'b0, e1, e3}, {30'b0, v.eerr, v.eerr});
    chk({v.name, " idle"}, {30'b0, rr1, rr3}, 32'h3);
  endtask
  initial begin
    int spur;
    vecs.push_back(mk(32'h00, 1, 3'b010, 32'h11111111, 32'h0, 0, "SW 0x00"));
    vecs.push_back(mk(32'h10, 1, 3'b010, 32'hDEADBEEF, 32'h0, 0, "SW 0x10"));
    vecs.push_back(mk(32'h10, 0, 3'b010, 32'h0, 32'hDEADBEEF, 0, "LW 0x10"));
    vecs.push_back(mk(32'h13, 0, 3'b000, 32'h0, 32'hFFFFFFDE, 0, "LB 0x13"));
    vecs.push_back(mk(32'h13, 0, 3'b100, 32'h0, 32'h000000DE, 0, "LBU 0x13"));
    vecs.push_back(mk(32'h12, 0, 3'b001, 32'h0, 32'hFFFFDEAD, 0, "LH 0x12"));
    vecs.push_back(mk(32'h10, 0, 3'b101, 32'h0, 32'h0000BEEF, 0, "LHU 0x10"));
    vecs.push_back(mk(32'h10, 0, 3'b000, 32'h0, 32'hFFFFFFEF, 0, "LB 0x10"));
    vecs.push_back(mk(32'h11, 1, 3'b000, 32'hAAAAAA55, 32'h0, 0, "SB 0x11"));
    vecs.push_back(mk(32'h10, 0, 3'b010, 32'h0, 32'hDEAD55EF, 0, "LW after SB"));
    vecs.push_back(mk(32'h12, 1, 3'b001, 32'hFFFF1234, 32'h0, 0, "SH 0x12"));
    vecs.push_back(mk(32'h10, 0, 3'b010, 32'h0, 32'h123455EF, 0, "LW after SH"));
    vecs.push_back(mk(32'h12, 0, 3'b101, 32'h0, 32'h00001234, 0, "LHU 0x12"));
    vecs.push_back(mk(32'h10, 0, 3'b001, 32'h0, 32'h000055EF, 0, "LH 0x10"));
    vecs.push_back(mk(32'h11, 0, 3'b100, 32'h0, 32'h00000055, 0, "LBU 0x11"));
    vecs.push_back(mk(32'h12, 0, 3'b000, 32'h0, 32'h00000034, 0, "LB 0x12"));
    vecs.push_back(mk(32'hFC, 1, 3'b010, 32'h0BADF00D, 32'h0, 0, "SW last word"));
    vecs.push_back(mk(32'hFC, 0, 3'b010, 32'h0, 32'h0BADF00D, 0, "LW last word"));
    vecs.push_back(mk(32'h12, 0, 3'b010, 32'h0, 32'h0, 1, "LW 0x12 misaligned"));
    vecs.push_back(mk(32'h11, 1, 3'b001, 32'h0, 32'h0, 1, "SH 0x11 misaligned"));
    vecs.push_back(mk(32'h13, 0, 3'b001, 32'h0, 32'h0, 1, "LH 0x13 misaligned"));
    vecs.push_back(mk(32'h11, 0, 3'b101, 32'h0, 32'h0, 1, "LHU 0x11 misaligned"));
    vecs.push_back(mk(32'h100, 0, 3'b010, 32'h0, 32'h0, 1, "LW 4*DEPTH range"));
    vecs.push_back(mk(32'h80000010, 0, 3'b010, 32'h0, 32'h0, 1, "LW high addr range"));
    vecs.push_back(mk(32'h10, 0, 3'b011, 32'h0, 32'h0, 1, "LD funct3 011"));
    vecs.push_back(mk(32'h10, 0, 3'b110, 32'h0, 32'h0, 1, "load funct3 110"));
    vecs.push_back(mk(32'h12, 1, 3'b010, 32'h0, 32'h0, 1, "SW 0x12 misaligned"));
    vecs.push_back(mk(32'h10, 1, 3'b100, 32'h0, 32'h0, 1, "store funct3 100"));
    vecs.push_back(mk(32'h100, 1, 3'b010, 32'h0, 32'h0, 1, "SW 4*DEPTH range"));
    vecs.push_back(mk(32'h10, 0, 3'b010, 32'h0, 32'h123455EF, 0, "LW 0x10 after faults"));
    vecs.push_back(mk(32'h00, 0, 3'b010, 32'h0, 32'h11111111, 0, "LW 0x00 no alias"));
    #2;
    chk("reset req_ready", {30'b0, rr1, rr3}, 32'h3);
    chk("reset rsp_valid", {30'b0, rv1, rv3}, 32'h0);
    chk("reset rsp_rdata1", rd1, 32'h0);
    chk("reset rsp_rdata3", rd3, 32'h0);
    chk("reset rsp_err", {30'b0, re1, re3}, 32'h0);
    @(negedge clk); rst = 1'b0;
    foreach (vecs[i]) xact(vecs[i]);
    // backpressure: a pending store request must be ignored while stalled in RESP
    @(negedge clk);
    req_addr = 32'h10; req_wren = 1'b0; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    req_wren = 1'b1; req_wdata = 32'h0; rsp_ready = 1'b0;
    for (int i = 0; i < 10 && !(rv1 && rv3); i++) begin @(posedge clk); #1; end
    chk("bp both valid", {30'b0, rv1, rv3}, 32'h3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp hold valid", {30'b0, rv1, rv3}, 32'h3);
      chk("bp hold ready", {30'b0, rr1, rr3}, 32'h0);
      chk("bp hold rdata1", rd1, 32'h123455EF);
      chk("bp hold rdata3", rd3, 32'h123455EF);
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release valid", {30'b0, rv1, rv3}, 32'h0);
    chk("bp release ready", {30'b0, rr1, rr3}, 32'h3);
    xact(mk(32'h10, 0, 3'b010, 32'h0, 32'h123455EF, 0, "LW after bp"));
    // asynchronous reset with DUT1 in RESP and DUT3 in WAIT
    xact(mk(32'h20, 1, 3'b010, 32'hCAFEF00D, 32'h0, 0, "SW 0x20"));
    @(negedge clk);
    req_addr = 32'h20; req_wren = 1'b0; req_funct3 = 3'b010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst state", {30'b0, rv1, rr3}, 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("async rst valid", {30'b0, rv1, rv3}, 32'h0);
    chk("async rst ready", {30'b0, rr1, rr3}, 32'h3);
    @(negedge clk); rst = 1'b0;
    spur = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rv1 || rv3) spur++;
    end
    chk("no rsp after rst", spur, 32'd0);
    xact(mk(32'h20, 0, 3'b010, 32'h0, 32'hCAFEF00D, 0, "LW 0x20 after rst"));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lsu_data_mem.md
Name: lsu_data_mem

Overview:
Parametrised byte-addressable data memory with a request/response handshake, the next-generation data-side memory for the RV32 core.
- Adds byte-lane write enables for SB/SH/SW.
- Adds sign- and zero-extended loads for LB/LH/LW/LBU/LHU.
- Adds misalignment, range and illegal-funct3 error reporting.
- Adds a configurable read latency.
Sits between the execute/memory stage and on-chip RAM. One transaction outstanding at a time.

Parameters:
DEPTH, 4096, number of 32-bit words; must be a power of two ≥ 2.
LATENCY, 1, cycles from request acceptance to response valid; must be ≥ 1.
INIT_ZERO, 0, 1 = array contents cleared by reset; 0 = array contents undefined after reset.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_addr  in  32  byte address
req_wren  in  1  0 = load, 1 = store
req_funct3  in  3  RISC-V funct3 (loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW)
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  out  1  transaction faulted

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, latency counter=0. Array is cleared only if INIT_ZERO=1.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch addr/wren/funct3/wdata, perform the error check, go to WAIT. Counter loads LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP with rsp_valid=1 from the next cycle.
  - Result: rsp_valid rises exactly LATENCY cycles after the accepting edge. LATENCY=1 means rsp_valid is high in the cycle after acceptance.
  - RESP: rsp_valid=1; rsp_rdata/rsp_err held stable. On rsp_ready, go to IDLE next cycle. No same-cycle turnaround: req_ready is 0 in the RESP cycle.
- Error conditions (rsp_err=1, no array write, rsp_rdata=0):
  - LH/LHU/SH with addr[0]=1.
  - LW/SW with addr[1:0]≠0.
  - Word index addr[31:2] ≥ DEPTH.
  - Load funct3 ∈ {011,110,111}.
  - Store funct3 ∉ {000,001,010}.
  - Errors take the same LATENCY as good transactions.
- Stores:
  - Byte lane = addr[1:0]. SB writes lane addr[1:0] with wdata[7:0]. SH writes lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0]. SW writes all lanes.
  - Other lanes are unchanged.
  - The write commits at the accepting edge.
  - Response: rsp_rdata=0, rsp_err=0.
- Loads:
  - The word is read at the accepting edge; the result is pipelined LATENCY stages.
  - Lane extraction:
    - LB/LBU take byte addr[1:0].
    - LH/LHU take the half selected by addr[1].
    - LB/LH sign-extend from bit 7/15.
    - LBU/LHU zero-extend.
    - LW passes the word unchanged.
  - A load following a store to the same word returns the stored data (the store has committed before the next acceptance).
- Width rules: the array index uses addr[$clog2(DEPTH)+1:2]. Upper address bits only feed the range check.
- Reset mid-transaction:
  - Returns to IDLE; any pending response is dropped; rsp_valid=0 immediately (asynchronous).
  - A store already committed stays committed.
- Backpressure: rsp_ready low holds RESP indefinitely with outputs stable. req_valid is ignored outside IDLE.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_rdata=0xDEADBEEF, rsp_err=0; rsp_valid rises LATENCY cycles after each acceptance (check LATENCY=1 and 3).
- After the word above, LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF; LB 0x10 → 0xFFFFFFEF.
- SB 0x11 data 0x55, then LW 0x10 → 0xDEAD55EF; SH 0x12 data 0x1234, then LW 0x10 → 0x123455EF.
- LW 0x12, SH 0x11, LH 0x13, LW at 4*DEPTH, LD funct3 011 → each gives rsp_err=1, rsp_rdata=0; the faulting SW leaves the array unchanged (re-read 0x10 unchanged).
- Hold rsp_ready=0 for 5 cycles with req_valid=1 → rsp_valid/rsp_rdata stable, req_ready=0, no second acceptance; release → exactly one handshake, then req_ready=1 next cycle.
- Assert rst during WAIT of an LW → rsp_valid=0 and req_ready=1 without a clock edge; no response later. A SW issued before that reset reads back correctly afterwards.
